// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared processor constants (datapath width, register address width, zero register)
// Used by the register file, the ALU and the decoder.
package wb_regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: write-back pipeline register holding one pending register write
// Ports: clk, rst_n (async active-low); in_valid/in_addr/in_data captured every edge;
//        wb_valid/wb_addr/wb_data present the staged write to the register file.
module wb_stage_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= in_valid;
            wb_addr  <= in_addr;
            wb_data  <= in_data;
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 2-read register file with a staged write-back and bypass of the staged value
// Ports: clk, rst_n (async active-low); inrs/inrt read addresses -> dataout1/dataout2 (combinational);
//        inrd/inaluresult/inrw ALU write request (staged one edge, committed the next);
//        wrcount saturating count of committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inrs,
    input  logic [ADDR_W-1:0] inrt,
    input  logic [ADDR_W-1:0] inrd,
    input  logic [DATA_W-1:0] inaluresult,
    input  logic              inrw,
    output logic [DATA_W-1:0] dataout1,
    output logic [DATA_W-1:0] dataout2,
    output logic [15:0]       wrcount
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inrw),
        .in_addr  (inrd),
        .in_data  (inaluresult),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    // A staged write to the zero register is dropped entirely, including from the count.
    assign commit = wb_valid && (wb_addr != ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wrcount <= '0;
        end else if (commit) begin
            regs[wb_addr] <= wb_data;
            if (wrcount != 16'hFFFF) wrcount <= wrcount + 16'd1;
        end
    end

    // The staged value is not yet in the array, so it is forwarded to any matching reader.
    always_comb begin
        dataout1 = (inrs == ZERO) ? '0 : (commit && inrs == wb_addr) ? wb_data : regs[inrs];
        dataout2 = (inrt == ZERO) ? '0 : (commit && inrt == wb_addr) ? wb_data : regs[inrt];
    end
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  inrs = '0, inrt = '0, inrd = '0;
    logic [31:0] inaluresult = '0;
    logic        inrw = 1'b0;
    logic [31:0] dataout1, dataout2;
    logic [15:0] wrcount;
    int          compared = 0;
    int          mismatched = 0;

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inrs        (inrs),
        .inrt        (inrt),
        .inrd        (inrd),
        .inaluresult (inaluresult),
        .inrw        (inrw),
        .dataout1    (dataout1),
        .dataout2    (dataout2),
        .wrcount     (wrcount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inrw = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_async_cnt", {16'd0, wrcount}, 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state: every address reads 0 on both ports
        step();
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            inrs = 5'(a);
            inrt = 5'(31 - a);
            #1;
            check("rst_rd1", dataout1, 32'd0);
            check("rst_rd2", dataout2, 32'd0);
        end
        check("rst_cnt", {16'd0, wrcount}, 32'd0);

        // Single write to r5: no same-cycle forwarding, bypass after edge 1, array after edge 2
        step();
        inrs = 5'd5; inrt = 5'd6;
        inrw = 1'b1; inrd = 5'd5; inaluresult = 32'h0000_000A;
        #1;
        check("w5_noforward", dataout1, 32'd0);
        step();
        inrw = 1'b0;
        #1;
        check("w5_bypass", dataout1, 32'h0000_000A);
        check("w5_other_port", dataout2, 32'd0);
        check("w5_cnt_before", {16'd0, wrcount}, 32'd0);
        step();
        check("w5_array", dataout1, 32'h0000_000A);
        check("w5_cnt", {16'd0, wrcount}, 32'd1);

        // Independent bypass: port 2 sees staged r9 while port 1 reads r5 from array
        inrw = 1'b1; inrd = 5'd9; inaluresult = 32'hDEAD_BEEF; inrt = 5'd9;
        step();
        inrw = 1'b0;
        #1;
        check("w9_port2_bypass", dataout2, 32'hDEAD_BEEF);
        check("w9_port1_array", dataout1, 32'h0000_000A);
        step();
        check("w9_cnt", {16'd0, wrcount}, 32'd2);

        // Writes to r0 are discarded and not counted
        do_reset();
        inrs = 5'd0; inrt = 5'd0;
        inrw = 1'b1; inrd = 5'd0; inaluresult = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w0_rd1", dataout1, 32'd0);
        end
        inrw = 1'b0;
        step();
        check("w0_rd1_end", dataout1, 32'd0);
        check("w0_cnt", {16'd0, wrcount}, 32'd0);

        // Back-to-back writes to r7, both ports on r7
        do_reset();
        inrs = 5'd7; inrt = 5'd7;
        inrw = 1'b1; inrd = 5'd7; inaluresult = 32'h11;
        step();
        check("b2b_p1_first", dataout1, 32'h11);
        check("b2b_p2_first", dataout2, 32'h11);
        inaluresult = 32'h22;
        step();
        check("b2b_p1_second", dataout1, 32'h22);
        check("b2b_p2_second", dataout2, 32'h22);
        inrw = 1'b0;
        step();
        step();
        check("b2b_p1_final", dataout1, 32'h22);
        check("b2b_p2_final", dataout2, 32'h22);
        check("b2b_cnt", {16'd0, wrcount}, 32'd2);

        // Reset between capture and commit drops the pending write
        do_reset();
        inrw = 1'b1; inrd = 5'd3; inaluresult = 32'h55; inrs = 5'd3; inrt = 5'd3;
        step();
        inrw = 1'b0;
        #1;
        check("midrst_bypass", dataout1, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_async", dataout1, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_first_cycle", dataout2, 32'd0);
        step();
        step();
        check("midrst_rd", dataout1, 32'd0);
        check("midrst_cnt", {16'd0, wrcount}, 32'd0);

        // Saturating write counter with inrw held high to r1
        do_reset();
        inrs = 5'd1;
        inrw = 1'b1; inrd = 5'd1;
        for (int i = 1; i <= 70000; i++) begin
            inaluresult = 32'(i);
            step();
            if (i == 100) check("sat_cnt_100", {16'd0, wrcount}, 32'd99);
            if (i == 65536) check("sat_cnt_max", {16'd0, wrcount}, 32'h0000_FFFF);
            if (i == 65537) check("sat_cnt_hold", {16'd0, wrcount}, 32'h0000_FFFF);
            inaluresult = 32'(i + 1);
        end
        inrw = 1'b0;
        #1;
        check("sat_bypass", dataout1, 32'd70000);
        step();
        check("sat_cnt_final", {16'd0, wrcount}, 32'h0000_FFFF);
        check("sat_array", dataout1, 32'd70000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
